// File: rtl/config_loader.sv
// config_loader: checks the sync byte and XOR checksum of a byte stream, then loads the tile and switch config all at once
module config_loader #(
  parameter int NUM_TILES = 6,
  parameter int NUM_SWITCHES = 2,
  parameter int LUT_BITS = 33,
  parameter int SW_BITS = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic [7:0] data_in,
  input  logic data_valid,
  output logic data_ready,
  output logic [NUM_TILES*LUT_BITS-1:0] tile_cfg,
  output logic [NUM_SWITCHES*SW_BITS-1:0] switch_cfg,
  output logic cfg_done,
  output logic cfg_error
);
  localparam int TW = NUM_TILES*LUT_BITS;
  localparam int SWW = NUM_SWITCHES*SW_BITS;
  localparam int TOTAL = TW + SWW;
  localparam int NUM_BYTES = (TOTAL + 7) / 8;
  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);
  typedef enum logic [1:0] {IDLE, HUNT, LOAD, CHECK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [SWW-1:0] sw_q, sw_d;
  logic done_q, done_d, err_q, err_d;
  logic xfer;
  assign data_ready = state_q != IDLE;
  assign xfer = data_valid & data_ready;
  assign tile_cfg = tile_q;
  assign switch_cfg = sw_q;
  assign cfg_done = done_q;
  assign cfg_error = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    shadow_d = shadow_q;
    tile_d = tile_q;
    sw_d = sw_q;
    done_d = done_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HUNT;
        cnt_d = '0;
        sum_d = '0;
        done_d = 1'b0;
        err_d = 1'b0;
      end
      HUNT: state_d = (xfer && data_in == SYNC_BYTE) ? LOAD : HUNT;
      LOAD: if (xfer) begin
        shadow_d[{cnt_q, 3'b000} +: 8] = data_in;
        sum_d = sum_q ^ data_in;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? CHECK : LOAD;
      end
      CHECK: if (xfer) begin
        state_d = IDLE;
        if (data_in == sum_q) begin
          tile_d = shadow_q[0 +: TW];
          sw_d = shadow_q[TW +: SWW];
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sum_q <= '0;
      shadow_q <= '0;
      tile_q <= '0;
      sw_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      shadow_q <= shadow_d;
      tile_q <= tile_d;
      sw_q <= sw_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed table-driven checks of config_loader stream validation and commit
module tb_config_loader;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] data_in = '0;
  logic data_valid = 1'b0;
  logic data_ready;
  logic [197:0] tile_cfg;
  logic [31:0] switch_cfg;
  logic cfg_done, cfg_error;
  int tests = 0;
  int failed = 0;
  typedef struct {
    logic [7:0] fill;
    int ia;
    logic [7:0] va;
    int ib;
    logic [7:0] vb;
    logic [7:0] chk;
    logic e_done;
    logic e_err;
    logic [197:0] e_tile;
    logic [31:0] e_sw;
  } vec_t;
  vec_t vecs[7];
  config_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .tile_cfg(tile_cfg),
    .switch_cfg(switch_cfg), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int n;
    repeat (gap) begin
      data_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    data_in = b;
    data_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      acc = data_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) check("byte_accept_timeout", 256'd0, 256'd1);
    data_valid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask
  task automatic run_stream(input logic [7:0] fill, input int ia, input logic [7:0] va,
                            input int ib, input logic [7:0] vb, input logic [7:0] chk,
                            input int gap, input int junk, input logic sc);
    pulse_start();
    if (junk > 0) send_byte(8'h00, gap);
    if (junk > 1) send_byte(8'h5A, gap);
    send_byte(8'hA5, gap);
    for (int k = 0; k < 29; k++) send_byte(k == ia ? va : (k == ib ? vb : fill), gap);
    check("done_before_chk", 256'(cfg_done), 256'd0);
    check("err_before_chk", 256'(cfg_error), 256'd0);
    start = sc;
    send_byte(chk, gap);
    start = 1'b0;
  endtask
  initial begin
    vecs[0] = '{8'hFF, 99, 8'h00, 99, 8'h00, 8'hFF, 1'b1, 1'b0, {198{1'b1}}, 32'hFFFF_FFFF};
    vecs[1] = '{8'h00, 99, 8'h00, 99, 8'h00, 8'h55, 1'b0, 1'b1, {198{1'b1}}, 32'hFFFF_FFFF};
    vecs[2] = '{8'h00, 0, 8'h01, 24, 8'h40, 8'h41, 1'b1, 1'b0, 198'h1, 32'h1};
    vecs[3] = '{8'h00, 99, 8'h00, 99, 8'h00, 8'h00, 1'b1, 1'b0, 198'h0, 32'h0};
    vecs[4] = '{8'h00, 0, 8'hA5, 28, 8'hC0, 8'h65, 1'b1, 1'b0, 198'hA5, 32'h0};
    vecs[5] = '{8'h00, 99, 8'h00, 99, 8'h00, 8'h01, 1'b0, 1'b1, 198'hA5, 32'h0};
    vecs[6] = '{8'h00, 4, 8'h01, 28, 8'h20, 8'h21, 1'b1, 1'b0, 198'h1_0000_0000, 32'h8000_0000};
    #12;
    check("rst_tile", 256'(tile_cfg), 256'd0);
    check("rst_sw", 256'(switch_cfg), 256'd0);
    check("rst_done", 256'(cfg_done), 256'd0);
    check("rst_err", 256'(cfg_error), 256'd0);
    check("rst_ready", 256'(data_ready), 256'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("idle_ready", 256'(data_ready), 256'd0);
    for (int i = 0; i < 7; i++) begin
      run_stream(vecs[i].fill, vecs[i].ia, vecs[i].va, vecs[i].ib, vecs[i].vb, vecs[i].chk, 0, 0, 1'b0);
      check($sformatf("v%0d_done", i), 256'(cfg_done), 256'(vecs[i].e_done));
      check($sformatf("v%0d_err", i), 256'(cfg_error), 256'(vecs[i].e_err));
      check($sformatf("v%0d_tile", i), 256'(tile_cfg), 256'(vecs[i].e_tile));
      check($sformatf("v%0d_sw", i), 256'(switch_cfg), 256'(vecs[i].e_sw));
      check($sformatf("v%0d_ready", i), 256'(data_ready), 256'd0);
    end
    run_stream(8'h00, 0, 8'h01, 24, 8'h40, 8'h41, 0, 2, 1'b0);
    check("junk_done", 256'(cfg_done), 256'd1);
    check("junk_tile", 256'(tile_cfg), 256'h1);
    check("junk_sw", 256'(switch_cfg), 256'h1);
    run_stream(8'h00, 99, 8'h00, 99, 8'h00, 8'h00, 0, 0, 1'b0);
    check("zero_tile", 256'(tile_cfg), 256'd0);
    run_stream(8'h00, 0, 8'h01, 24, 8'h40, 8'h41, 3, 0, 1'b0);
    check("stall_done", 256'(cfg_done), 256'd1);
    check("stall_err", 256'(cfg_error), 256'd0);
    check("stall_tile", 256'(tile_cfg), 256'h1);
    check("stall_sw", 256'(switch_cfg), 256'h1);
    run_stream(8'hFF, 99, 8'h00, 99, 8'h00, 8'hFF, 0, 0, 1'b1);
    check("sc_done", 256'(cfg_done), 256'd1);
    check("sc_ready", 256'(data_ready), 256'd0);
    @(posedge clock);
    #1;
    check("sc_ready_later", 256'(data_ready), 256'd0);
    check("sc_tile", 256'(tile_cfg), 256'({198{1'b1}}));
    pulse_start();
    send_byte(8'hA5, 0);
    for (int k = 0; k < 10; k++) send_byte(8'h3C, 0);
    check("mid_ready", 256'(data_ready), 256'd1);
    reset_n = 1'b0;
    #2;
    check("mid_rst_tile", 256'(tile_cfg), 256'd0);
    check("mid_rst_sw", 256'(switch_cfg), 256'd0);
    check("mid_rst_done", 256'(cfg_done), 256'd0);
    check("mid_rst_ready", 256'(data_ready), 256'd0);
    #5;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_ready", 256'(data_ready), 256'd0);
    run_stream(8'hFF, 99, 8'h00, 99, 8'h00, 8'hFF, 0, 0, 1'b0);
    check("post_rst_done", 256'(cfg_done), 256'd1);
    check("post_rst_tile", 256'(tile_cfg), 256'({198{1'b1}}));
    check("post_rst_sw", 256'(switch_cfg), 256'hFFFF_FFFF);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Upstream configuration stage for the FPGA fabric.
- Accepts a byte-wide configuration bitstream over a valid/ready handshake and validates its sync byte and XOR checksum.
- On a valid stream, atomically drives the flat configuration buses consumed by the logic tiles (33-bit LUT+mux words) and the 4x4 switch boxes (16-bit words).
- A failed stream never disturbs the live configuration.

Parameters:
- NUM_TILES, 6, number of logic tiles configured.
- NUM_SWITCHES, 2, number of switch boxes configured.
- LUT_BITS, 33, config bits per tile: bits [31:0] LUT, bit [32] FF/comb mux select.
- SW_BITS, 16, config bits per switch box.
- SYNC_BYTE, 8'hA5, stream start marker.

Derived values:
- TOTAL = NUM_TILES*LUT_BITS + NUM_SWITCHES*SW_BITS (default 230).
- NUM_BYTES = ceil(TOTAL/8) (default 29).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms loader from IDLE.
- data_in  in  8  bitstream byte.
- data_valid  in  1  data_in valid.
- data_ready  out  1  loader can accept a byte.
- tile_cfg  out  NUM_TILES*LUT_BITS  tile i config at [i*LUT_BITS +: LUT_BITS].
- switch_cfg  out  NUM_SWITCHES*SW_BITS  switch j config at [j*SW_BITS +: SW_BITS].
- cfg_done  out  1  last stream committed successfully (level).
- cfg_error  out  1  last stream failed checksum (level).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - tile_cfg, switch_cfg, shadow register, byte counter and running checksum all 0.
  - cfg_done=0, cfg_error=0, data_ready=0.
- Handshake:
  - A byte transfers on a rising edge where data_valid & data_ready.
  - data_ready is a registered-state decode: 1 in HUNT, LOAD and CHECK; 0 in IDLE.
  - data_valid low stalls the loader indefinitely; there is no timeout.
- States:
  - IDLE: start=1 -> HUNT; clear cfg_done, cfg_error, counter and checksum.
  - HUNT: each accepted byte equal to SYNC_BYTE -> LOAD; any other accepted byte is discarded and the loader stays in HUNT.
  - LOAD:
    - Accepted byte k (0..NUM_BYTES-1) is written to shadow bits [8k +: 8], LSB-first; shadow payload bit p = byte p/8, bit p%8.
    - checksum ^= byte.
    - When k = NUM_BYTES-1 is accepted -> CHECK.
  - CHECK: accept one checksum byte.
    - If it equals the running checksum: tile_cfg <= shadow[0 +: NUM_TILES*LUT_BITS]; switch_cfg <= shadow[NUM_TILES*LUT_BITS +: NUM_SWITCHES*SW_BITS]; cfg_done <= 1.
    - Otherwise: outputs unchanged; cfg_error <= 1.
    - Either way -> IDLE.
- Latency: config outputs and flags update on the same edge that accepts the checksum byte, so they are visible the following cycle.
- Padding bits [TOTAL, 8*NUM_BYTES) are stored in shadow only. They are included in the checksum but never drive outputs.
- start is ignored outside IDLE. start asserted on the commit edge is also ignored, because the state is still CHECK on that edge.
- cfg_done and cfg_error are mutually exclusive. They hold until the next start or reset.
- Reset mid-stream (any state) returns all outputs to 0, including previously committed config.
- Byte counter is sized ceil(log2(NUM_BYTES+1)) and never wraps within a stream.
- A SYNC_BYTE value inside the payload is treated as data. There is no resync.

Test Plan:
- Reset, start, then 8'hA5, 29 bytes of 8'hFF, checksum 8'hFF -> tile_cfg and switch_cfg all ones; cfg_done=1 the cycle after the checksum edge; data_ready=0 afterwards.
- start, then 8'hA5; byte0=8'h01, byte24=8'h40, all other payload bytes 8'h00; checksum 8'h41 -> only tile_cfg[0]=1 and switch_cfg[0]=1 (payload bit 198); all other bits 0.
- After the first scenario, send a full stream of 8'h00 with checksum 8'h55 -> cfg_error=1, cfg_done=0, outputs still all ones.
- start, then 8'h00, 8'h5A, 8'hA5, then the second scenario's payload -> first two bytes are discarded; result identical to the second scenario.
- Second scenario with data_valid toggled low for 3 cycles between every byte -> identical result; no byte is lost or duplicated.
- After the first scenario, start and 10 payload bytes, then pulse reset_n low -> tile_cfg=0, switch_cfg=0, cfg_done=0, data_ready=0, state IDLE; a subsequent full valid stream commits normally.
